frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Ping-pong frame buffer manager that shares the single-port byte-wide SPRAM between the camera pixel writer and the SPI slave reader. Two frame banks of FRAME_BYTES bytes are held in SPRAM. The writer fills one bank while the other is published to the SPI slave through `buffer_ready`. This block owns the SPRAM port: it arbitrates per cycle, adds the bank base offsets, sequences bank swaps on frame boundaries, and counts frames dropped while the reader holds the published bank.

## Interface
Parameters:
- FRAME_BYTES, 9600, bytes per frame (one bank)
- RD_AW, 17, width of reader byte address
- MEM_AW, 15, SPRAM byte address width (must hold 2*FRAME_BYTES)

Ports:
- clk  in  1  system clock (48 MHz); single clock domain
- reset  in  1  synchronous, active-high reset
- wr_req  in  1  writer has a byte to store this cycle
- wr_addr  in  MEM_AW  writer byte offset within frame (0..FRAME_BYTES-1)
- wr_data  in  8  writer byte
- wr_ack  out  1  combinational; equals wr_req (writer always wins)
- frame_wr_done  in  1  one-cycle pulse: writer finished current frame
- rd_addr  in  RD_AW  SPI slave byte offset within published frame
- rd_data  out  8  registered byte for rd_addr
- buffer_ready  out  1  published frame available to SPI slave
- frame_read_complete  in  1  one-cycle pulse from SPI slave: frame consumed
- mem_addr  out  MEM_AW  registered SPRAM byte address
- mem_wdata  out  8  registered SPRAM write data
- mem_we  out  1  registered SPRAM write enable
- mem_rdata  in  8  SPRAM read data, valid 1 cycle after address presented
- wr_bank  out  1  bank currently being written
- frames_dropped  out  8  saturating count of overwritten frames

## Operation
- Bank bases: bank 0 at 0, bank 1 at FRAME_BYTES. The read bank is always `~wr_bank`.
- Buffer FSM, 2 states:
  - EMPTY (buffer_ready=0): on frame_wr_done, toggle wr_bank and go to PUBLISHED. frame_read_complete is ignored in this state.
  - PUBLISHED (buffer_ready=1), handled on the frame_wr_done / frame_read_complete combination:
    - frame_read_complete alone: go to EMPTY.
    - frame_wr_done alone: no swap. frames_dropped increments, saturating at 255. The writer overwrites the same bank.
    - Both in the same cycle: toggle wr_bank and stay PUBLISHED. buffer_ready remains 1. No drop is counted.
- Port arbitration, evaluated every cycle:
  - Write slot when wr_req=1:
    - If wr_addr < FRAME_BYTES: mem_addr <= wr_bank base + wr_addr, mem_wdata <= wr_data, mem_we <= 1.
    - If wr_addr ≥ FRAME_BYTES: the write is dropped (mem_we <= 0) but still acknowledged.
  - Read slot otherwise:
    - If rd_addr < FRAME_BYTES: mem_addr <= read bank base + rd_addr, mem_we <= 0, and a 2-stage read tag pipeline is marked valid.
    - If rd_addr ≥ FRAME_BYTES: no memory access. The tag is marked "zero", and rd_data later loads 8'h00.
- Tag pipeline stage 2:
  - valid → rd_data <= mem_rdata
  - zero → rd_data <= 0
  - otherwise rd_data holds its value
- Bank selection uses the wr_bank value registered at the start of the cycle. A write in the same cycle as frame_wr_done lands in the old bank.
- The writer is required to leave ≥1 idle cycle between requests at least every 2 cycles. Reader starvation is therefore bounded to one extra cycle.

## Timing
- Reset values:
  - state EMPTY, wr_bank 0, buffer_ready 0, frames_dropped 0
  - mem_addr 0, mem_wdata 0, mem_we 0, rd_data 0
  - read tags cleared
- Reset asserted mid-frame discards the published frame and returns to these values next edge.
- FSM latency:
  - frame_wr_done at edge n → wr_bank/buffer_ready updated at n+1.
  - frame_read_complete at edge n → buffer_ready low at n+1.
- Write path: wr_req sampled at edge n → mem_we/mem_addr valid in cycle n+1. Write latency is 1 cycle.
- Read path: read slot decided at edge n → mem_addr in cycle n+1 → mem_rdata in cycle n+2 → rd_data valid from edge n+3.
  - Uncontended rd_addr→rd_data latency is 3 cycles.
  - With one write stall it is 4 cycles.
  - The SPI slave samples only after its SCK synchronizer delay (≥4 cycles), so this latency is hidden.
- A swap occurring during the read pipeline does not flush in-flight tags. Data already issued completes from the old bank.

## Test plan
- Reset then single frame:
  - Stimulus: write 9600 bytes (value = addr[7:0]) with wr_req every other cycle, then pulse frame_wr_done.
  - Response: wr_bank=1, buffer_ready=1 next cycle. rd_addr=0x1234 gives rd_data=0x34 within 3 cycles, with mem_addr=0x1234 in bank 0.
- Read complete:
  - Stimulus: in PUBLISHED, pulse frame_read_complete.
  - Response: buffer_ready=0 next cycle. A further pulse in EMPTY has no effect.
- Dropped frame:
  - Stimulus: in PUBLISHED, issue 3 frame_wr_done pulses with no read complete.
  - Response: frames_dropped=3, wr_bank unchanged, writes go to base 9600.
  - Extension: force 300 drops; frames_dropped=255.
- Simultaneous events:
  - Stimulus: frame_wr_done and frame_read_complete on the same edge in PUBLISHED.
  - Response: wr_bank toggles, buffer_ready stays 1, frames_dropped unchanged.
- Contention and range:
  - Stimulus: wr_req held with a 1-idle gap while rd_addr changes; separately, rd_addr=9600 and wr_addr=9700.
  - Response: writes never lost (mem_we pattern matches wr_req); rd_data=0x00; mem_we=0 for the out-of-range write.
- Mid-operation reset:
  - Stimulus: assert reset during PUBLISHED with reads in flight.
  - Response: all outputs return to reset values at the next edge; no mem_we asserted after it.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: ping-pong SPRAM frame buffer with writer-priority port arbitration and bank swap FSM
module frame_buffer_arbiter #(
  parameter int FRAME_BYTES = 9600,
  parameter int RD_AW = 17,
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [MEM_AW-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  input  logic              frame_wr_done,
  input  logic [RD_AW-1:0]  rd_addr,
  output logic [7:0]        rd_data,
  output logic              buffer_ready,
  input  logic              frame_read_complete,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              wr_bank,
  output logic [7:0]        frames_dropped
);
  typedef enum logic {S_EMPTY, S_PUBLISHED} state_t;
  localparam logic [MEM_AW-1:0] FB_M = MEM_AW'(FRAME_BYTES);
  localparam logic [RD_AW-1:0]  FB_R = RD_AW'(FRAME_BYTES);
  state_t            r_state, w_state_nxt;
  logic              r_wr_bank, w_bank_nxt, w_drop_inc;
  logic [7:0]        r_drop, r_rd_data, r_mem_wdata;
  logic [MEM_AW-1:0] r_mem_addr, w_wr_base, w_rd_base;
  logic              r_mem_we, r_tag1_v, r_tag1_z, r_tag2_v, r_tag2_z;
  logic              w_wr_in, w_rd_in;
  always_comb begin
    w_state_nxt = r_state;
    w_bank_nxt  = r_wr_bank;
    w_drop_inc  = 1'b0;
    if (r_state == S_EMPTY) begin
      if (frame_wr_done) begin
        w_bank_nxt  = ~r_wr_bank;
        w_state_nxt = S_PUBLISHED;
      end
    end else if (frame_wr_done && frame_read_complete) begin
      w_bank_nxt = ~r_wr_bank;
    end else if (frame_read_complete) begin
      w_state_nxt = S_EMPTY;
    end else if (frame_wr_done) begin
      w_drop_inc = 1'b1;
    end
  end
  assign w_wr_base = r_wr_bank ? FB_M : '0;
  assign w_rd_base = r_wr_bank ? '0 : FB_M;
  assign w_wr_in   = wr_addr < FB_M;
  assign w_rd_in   = rd_addr < FB_R;
  // Read tags travel alongside the SPRAM latency so a bank swap never redirects an issued read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_wr_bank   <= 1'b0;
      r_drop      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rd_data   <= '0;
      r_tag1_v    <= 1'b0;
      r_tag1_z    <= 1'b0;
      r_tag2_v    <= 1'b0;
      r_tag2_z    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_bank <= w_bank_nxt;
      if (w_drop_inc && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      r_tag1_v <= ~wr_req & w_rd_in;
      r_tag1_z <= ~wr_req & ~w_rd_in;
      r_tag2_v <= r_tag1_v;
      r_tag2_z <= r_tag1_z;
      if (r_tag2_v) r_rd_data <= mem_rdata;
      else if (r_tag2_z) r_rd_data <= '0;
      if (wr_req) begin
        r_mem_we <= w_wr_in;
        if (w_wr_in) begin
          r_mem_addr  <= w_wr_base + wr_addr;
          r_mem_wdata <= wr_data;
        end
      end else begin
        r_mem_we <= 1'b0;
        if (w_rd_in) r_mem_addr <= w_rd_base + rd_addr[MEM_AW-1:0];
      end
    end
  end
  assign wr_ack         = wr_req;
  assign buffer_ready   = r_state == S_PUBLISHED;
  assign wr_bank        = r_wr_bank;
  assign frames_dropped = r_drop;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_we         = r_mem_we;
  assign rd_data        = r_rd_data;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: vector table, directed corner sequences and a randomized run against a frame-level model
module tb_frame_buffer_arbiter;
  localparam int FB = 9600;
  logic        clk = 1'b0;
  logic        reset, wr_req, wr_ack, frame_wr_done, frame_read_complete;
  logic [14:0] wr_addr, mem_addr;
  logic [7:0]  wr_data, rd_data, mem_wdata, mem_rdata, frames_dropped;
  logic [16:0] rd_addr;
  logic        buffer_ready, mem_we, wr_bank;
  logic [7:0]  ram [0:2*FB-1];
  int          mdl [0:2*FB-1];
  int          n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  frame_buffer_arbiter dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .frame_wr_done(frame_wr_done), .rd_addr(rd_addr), .rd_data(rd_data),
    .buffer_ready(buffer_ready), .frame_read_complete(frame_read_complete),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .wr_bank(wr_bank), .frames_dropped(frames_dropped)
  );
  always @(posedge clk) begin
    if (mem_we && int'(mem_addr) < 2*FB) ram[mem_addr] <= mem_wdata;
    mem_rdata <= (int'(mem_addr) < 2*FB) ? ram[mem_addr] : 8'h00;
  end
  typedef struct {
    logic wr_req; int wa; int wd; int ra; logic fwd; logic frc;
    logic e_we; int e_addr; logic e_rdy; logic e_bank; int e_drop;
  } vec_t;
  vec_t tv [9];
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    frame_wr_done = 1'b0; frame_read_complete = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, " mem_we"}, int'(mem_we), 0);
    chk({nm, " mem_addr"}, int'(mem_addr), 0);
    chk({nm, " mem_wdata"}, int'(mem_wdata), 0);
    chk({nm, " rd_data"}, int'(rd_data), 0);
    chk({nm, " buffer_ready"}, int'(buffer_ready), 0);
    chk({nm, " wr_bank"}, int'(wr_bank), 0);
    chk({nm, " frames_dropped"}, int'(frames_dropped), 0);
  endtask
  task automatic pulse_wr_done();
    frame_wr_done = 1'b1;
    tick();
    frame_wr_done = 1'b0;
    tick();
  endtask
  initial begin
    int m_bank, m_rdy, m_drop, e_rd, e_addr, e_wdata, v, wa, ra;
    logic e_we, prev_wr;
    int rq [$];
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tv[0] = '{1'b1, 5,    8'hA5, 0,    1'b0, 1'b0, 1'b1, 5,      1'b0, 1'b0, 0};
    tv[1] = '{1'b0, 0,    0,     3,    1'b0, 1'b1, 1'b0, FB+3,   1'b0, 1'b0, 0};
    tv[2] = '{1'b1, 9700, 8'h11, 0,    1'b0, 1'b0, 1'b0, FB+3,   1'b0, 1'b0, 0};
    tv[3] = '{1'b1, 7,    8'h3C, 0,    1'b1, 1'b0, 1'b1, 7,      1'b1, 1'b1, 0};
    tv[4] = '{1'b0, 0,    0,     10,   1'b0, 1'b0, 1'b0, 10,     1'b1, 1'b1, 0};
    tv[5] = '{1'b1, 2,    8'h77, 0,    1'b1, 1'b0, 1'b1, FB+2,   1'b1, 1'b1, 1};
    tv[6] = '{1'b0, 0,    0,     20,   1'b1, 1'b1, 1'b0, 20,     1'b1, 1'b0, 1};
    tv[7] = '{1'b1, 9599, 8'hC3, 0,    1'b0, 1'b1, 1'b1, 9599,   1'b0, 1'b0, 1};
    tv[8] = '{1'b0, 0,    0,     9600, 1'b0, 1'b0, 1'b0, 9599,   1'b0, 1'b0, 1};
    for (int i = 0; i < 9; i++) begin
      wr_req = tv[i].wr_req; wr_addr = 15'(tv[i].wa); wr_data = 8'(tv[i].wd);
      rd_addr = 17'(tv[i].ra); frame_wr_done = tv[i].fwd; frame_read_complete = tv[i].frc;
      #1 chk($sformatf("vec%0d wr_ack", i), int'(wr_ack), int'(tv[i].wr_req));
      tick();
      chk($sformatf("vec%0d mem_we", i), int'(mem_we), int'(tv[i].e_we));
      chk($sformatf("vec%0d mem_addr", i), int'(mem_addr), tv[i].e_addr);
      if (tv[i].e_we) chk($sformatf("vec%0d mem_wdata", i), int'(mem_wdata), tv[i].wd);
      chk($sformatf("vec%0d buffer_ready", i), int'(buffer_ready), int'(tv[i].e_rdy));
      chk($sformatf("vec%0d wr_bank", i), int'(wr_bank), int'(tv[i].e_bank));
      chk($sformatf("vec%0d frames_dropped", i), int'(frames_dropped), tv[i].e_drop);
    end
    idle();
    do_reset();
    for (int a = 0; a < FB; a++) begin
      wr_req = 1'b1; wr_addr = 15'(a); wr_data = 8'(a);
      tick();
      wr_req = 1'b0;
      tick();
    end
    frame_wr_done = 1'b1;
    tick();
    frame_wr_done = 1'b0;
    chk("frame wr_bank", int'(wr_bank), 1);
    chk("frame buffer_ready", int'(buffer_ready), 1);
    rd_addr = 17'h1234;
    tick();
    chk("read mem_addr", int'(mem_addr), 'h1234);
    tick();
    tick();
    chk("read rd_data", int'(rd_data), 'h34);
    rd_addr = 17'(FB);
    tick(); tick(); tick();
    chk("oor rd_data", int'(rd_data), 0);
    for (int k = 0; k < 3; k++) pulse_wr_done();
    chk("drop3 count", int'(frames_dropped), 3);
    chk("drop3 wr_bank", int'(wr_bank), 1);
    chk("drop3 ready", int'(buffer_ready), 1);
    wr_req = 1'b1; wr_addr = 15'd5; wr_data = 8'h5A;
    tick();
    wr_req = 1'b0;
    chk("drop3 mem_we", int'(mem_we), 1);
    chk("drop3 mem_addr", int'(mem_addr), FB + 5);
    frame_wr_done = 1'b1; frame_read_complete = 1'b1;
    tick();
    frame_wr_done = 1'b0; frame_read_complete = 1'b0;
    chk("simul wr_bank", int'(wr_bank), 0);
    chk("simul ready", int'(buffer_ready), 1);
    chk("simul drops", int'(frames_dropped), 3);
    frame_read_complete = 1'b1;
    tick();
    chk("rdcomp ready", int'(buffer_ready), 0);
    tick();
    frame_read_complete = 1'b0;
    chk("empty rdcomp ready", int'(buffer_ready), 0);
    chk("empty rdcomp bank", int'(wr_bank), 0);
    pulse_wr_done();
    chk("republish bank", int'(wr_bank), 1);
    chk("republish ready", int'(buffer_ready), 1);
    for (int k = 0; k < 300; k++) pulse_wr_done();
    chk("saturate drops", int'(frames_dropped), 255);
    chk("saturate bank", int'(wr_bank), 1);
    rd_addr = 17'h10;
    tick();
    rd_addr = 17'h11;
    tick();
    reset = 1'b1; wr_req = 1'b1; wr_addr = 15'd1; wr_data = 8'hEE;
    tick();
    chk_reset_vals("midreset");
    reset = 1'b0; wr_req = 1'b0; rd_addr = 17'(FB);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("postreset%0d mem_we", k), int'(mem_we), 0);
      chk($sformatf("postreset%0d rd_data", k), int'(rd_data), 0);
    end
    idle();
    do_reset();
    for (int i = 0; i < 2*FB; i++) begin
      ram[i] = 8'h00;
      mdl[i] = 0;
    end
    m_bank = 0; m_rdy = 0; m_drop = 0; e_rd = 0; e_addr = 0; e_wdata = 0; prev_wr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      wr_req = prev_wr ? 1'b0 : 1'($urandom_range(0, 1));
      prev_wr = wr_req;
      wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(FB, 32767)) : int'($urandom_range(0, FB - 1));
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(FB, 131071)) : int'($urandom_range(0, FB - 1));
      wr_addr = 15'(wa); wr_data = 8'($urandom); rd_addr = 17'(ra);
      frame_wr_done = ($urandom_range(0, 15) == 0);
      frame_read_complete = ($urandom_range(0, 7) == 0);
      if (wr_req) begin
        e_we = (wa < FB);
        if (e_we) begin
          e_addr = m_bank * FB + wa;
          e_wdata = int'(wr_data);
          mdl[e_addr] = e_wdata;
        end
        rq.push_back(-1);
      end else begin
        e_we = 1'b0;
        if (ra < FB) begin
          e_addr = (1 - m_bank) * FB + ra;
          rq.push_back(mdl[e_addr]);
        end else rq.push_back(0);
      end
      if (m_rdy == 0) begin
        if (frame_wr_done) begin m_bank = 1 - m_bank; m_rdy = 1; end
      end else if (frame_wr_done && frame_read_complete) m_bank = 1 - m_bank;
      else if (frame_read_complete) m_rdy = 0;
      else if (frame_wr_done && m_drop < 255) m_drop++;
      #1 chk("rand wr_ack", int'(wr_ack), int'(wr_req));
      tick();
      while (rq.size() > 2) begin
        v = rq.pop_front();
        if (v >= 0) e_rd = v;
      end
      chk($sformatf("rand%0d mem_we", c), int'(mem_we), int'(e_we));
      chk($sformatf("rand%0d mem_addr", c), int'(mem_addr), e_addr);
      if (e_we) chk($sformatf("rand%0d mem_wdata", c), int'(mem_wdata), e_wdata);
      chk($sformatf("rand%0d wr_bank", c), int'(wr_bank), m_bank);
      chk($sformatf("rand%0d buffer_ready", c), int'(buffer_ready), m_rdy);
      chk($sformatf("rand%0d frames_dropped", c), int'(frames_dropped), m_drop);
      chk($sformatf("rand%0d rd_data", c), int'(rd_data), e_rd);
    end
    idle();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
